i2c_mem_seq: RTL
================

Name: i2c_mem_seq

Overview:
- Command sequencer directly upstream of i2c_master_top; drives its chip-select register interface (prer/ctr/txr/cr/cs_i, ack_o, sr_o, rxr_o).
- Converts a single-byte memory request (slave addr, mem addr, wdata, rd/wr) into the full register-access sequence: START/addr, mem addr, data or repeated-START/read, STOP.
- Polls TIP, checks RxACK and arbitration-lost, and returns read data plus status to a simple valid/ready client.

Parameters:
PRESCALE, 16'h00c8, value programmed into prer at init.
ACK_TIMEOUT, 64, max cycles cs_o may wait for ack_i before aborting (8-bit counter, saturating).

Ports:
wb_clk_i  in  1  clock
arst_i  in  1  async reset, active low
req_valid_i  in  1  request strobe
req_ready_o  out  1  sequencer idle, accepts request
req_rw_i  in  1  1=read, 0=write
req_sadr_i  in  7  I2C slave address
req_madr_i  in  8  slave memory address
req_wdata_i  in  8  write data
rsp_valid_o  out  1  one-cycle completion pulse
rsp_rdata_o  out  8  read data, held until next rsp
rsp_err_o  out  2  00 ok, 01 NACK, 10 arbitration lost, 11 access timeout
prer_o  out  16  to master prer_i
ctr_o  out  8  to master ctr_i
txr_o  out  8  to master txr_i
cr_o  out  8  to master cr_i
cs_o  out  1  to master cs_i
ack_i  in  1  from master ack_o
sr_i  in  8  from master sr_o ([7] RxACK, [5] AL, [1] TIP)
rxr_i  in  8  from master rxr_o

Behaviour:
- Clock/reset: one clock wb_clk_i; reset arst_i is asynchronous, active low. On reset: all outputs 0 (prer_o=0, ctr_o=0, cs_o=0, req_ready_o=0, rsp_*=0), FSM to INIT_PRER. Reset mid-transaction aborts silently; no rsp pulse.
- Access rule: master latches all of prer/ctr/txr/cr on every cs access, so prer_o and ctr_o are held stable after init. An access asserts cs_o with the data valid in the same cycle. cs_o is held until ack_i is sampled 1, then dropped the next cycle. At least one idle cycle separates accesses. A poll access is cs_o=1 with cr_o=8'h00; sr_i is sampled in the ack_i cycle.
- Timeout: wait counter cleared at cs_o rise. If ack_i is not seen within ACK_TIMEOUT cycles: drop cs_o, rsp err=11, go to IDLE without sending STOP.
- Command codes (cr_o): STA=8'h80, STO=8'h40, RD=8'h20, WR=8'h10, NACK=8'h08.
- FSM states: INIT_PRER, INIT_EN, IDLE, ISSUE, POLL, CHECK, STOP_ISSUE, STOP_POLL, RESP.
- INIT_PRER: prer_o=PRESCALE, ctr_o=0. INIT_EN: ctr_o=8'h80. Then IDLE with req_ready_o=1.
- Request acceptance: on req_valid_i&req_ready_o, capture all request fields and set step index 0; req_ready_o=0 until RESP.
- Write steps:
  - txr {sadr,0}, cr 8'h90
  - txr madr, cr 8'h10
  - txr wdata, cr 8'h50
- Read steps:
  - txr {sadr,0}, cr 8'h90
  - txr madr, cr 8'h10
  - txr {sadr,1}, cr 8'h90
  - cr 8'h68 (RD+NACK+STO; txr unchanged)
- Per step: ISSUE, then POLL repeated until sr_i[1]=0, then CHECK.
- CHECK priority:
  - AL (sr_i[5]=1) -> err 10, RESP, no STOP.
  - Else RxACK (sr_i[7]=1) on any WR step -> err 01, STOP_ISSUE (cr 8'h40), STOP_POLL until TIP=0, then RESP.
  - Else advance to next step. After the last step, capture rxr_i into rsp_rdata_o (reads only), then RESP.
- RESP: rsp_valid_o=1 for exactly one cycle, then IDLE. rsp_rdata_o is unchanged on writes and on errors.
- Stability: req_* inputs are ignored while busy. Back-to-back requests are allowed; a request arriving in the RESP cycle is accepted only after returning to IDLE (ready=1).

Decomposition:
- Package i2c_seq_pkg:
  - cr command constants (STA/STO/RD/WR/NACK)
  - sr bit indices (RXACK=7, AL=5, TIP=1)
  - rsp_err encodings
  - FSM state enum
- Sub-module i2c_reg_access: one cs/ack access with timeout counter; outputs done, timeout, sampled sr.

Test Plan:
- Write, with the slave model at 7'h10: sadr=7'h10, madr=8'h01, wdata=8'hA5 -> txr/cr sequence (20/90, 01/10, A5/50); rsp err=00 after ~3 byte times; slave mem[1]=A5.
- Read: sadr=7'h10, madr=8'h01 after the write above -> sequence ends with cr=8'h68; rsp_rdata_o=8'hA5, err=00.
- NACK: sadr=7'h11 (absent) -> CHECK after step 0 sees RxACK=1; cr 8'h40 issued; rsp err=01; no further steps.
- Timeout: ack_i forced 0 -> cs_o drops after ACK_TIMEOUT cycles; rsp err=11; ready=1 next cycle.
- Reset: arst_i low during step 1 of a write -> all outputs 0 immediately; re-init writes prer=00c8 and ctr=80; no rsp pulse.
- Back-to-back: write 5A to 02, then read 02 with req_valid_i held -> two rsp pulses; second returns 8'h5A.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared constants and state encoding for the I2C memory sequencer.
// Command codes, status bit positions and response error codes.
package i2c_seq_pkg;

  localparam logic [7:0] CR_STA  = 8'h80;
  localparam logic [7:0] CR_STO  = 8'h40;
  localparam logic [7:0] CR_RD   = 8'h20;
  localparam logic [7:0] CR_WR   = 8'h10;
  localparam logic [7:0] CR_NACK = 8'h08;
  localparam logic [7:0] CTR_EN  = 8'h80;

  localparam int SR_RXACK = 7;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_AL   = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [3:0] {
    S_INIT_PRER,
    S_INIT_EN,
    S_IDLE,
    S_ISSUE,
    S_POLL,
    S_CHECK,
    S_STOP_ISSUE,
    S_STOP_POLL,
    S_RESP
  } state_t;

  function automatic logic [7:0] step_cr(
    input logic       rw,
    input logic [1:0] step
  );
    case (step)
      2'd0:    return CR_STA | CR_WR;
      2'd1:    return CR_WR;
      2'd2:    return rw ? (CR_STA | CR_WR) : (CR_WR | CR_STO);
      default: return CR_RD | CR_NACK | CR_STO;
    endcase
  endfunction

endpackage

// File: rtl/i2c_mem_seq_access.sv
// One chip-select access to the byte controller register file.
// Holds cs until ack, or gives up after ACK_TIMEOUT cycles.
module i2c_reg_access #(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ack,
  input  logic [7:0] sr,
  output logic       cs,
  output logic       done,
  output logic       timeout,
  output logic [7:0] sr_q
);

  localparam logic [7:0] LIM = 8'(ACK_TIMEOUT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs      <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      cnt     <= '0;
      sr_q    <= '0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      if (!cs) begin
        if (start) begin
          cs  <= 1'b1;
          cnt <= '0;
        end
      end else if (ack) begin
        cs   <= 1'b0;
        done <= 1'b1;
        sr_q <= sr;
      end else if (cnt == LIM) begin
        cs      <= 1'b0;
        timeout <= 1'b1;
      end else if (cnt != 8'hff) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_mem_seq.sv
// Turns single-byte memory requests into byte-controller register
// accesses: START/addr, mem addr, data or re-START/read, STOP.
module i2c_mem_seq
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALE    = 16'h00c8,
  parameter int          ACK_TIMEOUT = 64
) (
  input  logic        wb_clk_i,
  input  logic        arst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rw_i,
  input  logic [6:0]  req_sadr_i,
  input  logic [7:0]  req_madr_i,
  input  logic [7:0]  req_wdata_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_rdata_o,
  output logic [1:0]  rsp_err_o,
  output logic [15:0] prer_o,
  output logic [7:0]  ctr_o,
  output logic [7:0]  txr_o,
  output logic [7:0]  cr_o,
  output logic        cs_o,
  input  logic        ack_i,
  input  logic [7:0]  sr_i,
  input  logic [7:0]  rxr_i
);

  state_t     state;
  logic       act, go, done, tmo;
  logic [1:0] step, last_step;
  logic       rw, wr_step;
  logic [6:0] sadr;
  logic [7:0] madr, wdata, txr_n, sr_q;
  logic       sr_unused;

  i2c_reg_access #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_acc (
    .clk     (wb_clk_i),
    .rst_n   (arst_i),
    .start   (go),
    .ack     (ack_i),
    .sr      (sr_i),
    .cs      (cs_o),
    .done    (done),
    .timeout (tmo),
    .sr_q    (sr_q)
  );

  assign sr_unused = ^{sr_q[6], sr_q[4:2], sr_q[0]};
  assign last_step = rw ? 2'd3 : 2'd2;
  assign wr_step   = !(rw && step == 2'd3);

  always_comb begin
    txr_n = {sadr, 1'b0};
    case (step)
      2'd1:    txr_n = madr;
      2'd2:    txr_n = rw ? {sadr, 1'b1} : wdata;
      2'd3:    txr_n = txr_o;
      default: txr_n = {sadr, 1'b0};
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state       <= S_INIT_PRER;
      act         <= 1'b0;
      go          <= 1'b0;
      step        <= '0;
      rw          <= 1'b0;
      sadr        <= '0;
      madr        <= '0;
      wdata       <= '0;
      prer_o      <= '0;
      ctr_o       <= '0;
      txr_o       <= '0;
      cr_o        <= '0;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= '0;
    end else begin
      go          <= 1'b0;
      rsp_valid_o <= 1'b0;
      if (act && tmo) begin
        act <= 1'b0;
        if (state == S_INIT_PRER || state == S_INIT_EN) begin
          state <= S_INIT_PRER;
        end else begin
          rsp_err_o   <= ERR_TMO;
          rsp_valid_o <= 1'b1;
          state       <= S_RESP;
        end
      end else begin
        unique case (state)
          S_INIT_PRER: begin
            if (!act) begin
              prer_o <= PRESCALE;
              ctr_o  <= '0;
              cr_o   <= '0;
              go     <= 1'b1;
              act    <= 1'b1;
            end else if (done) begin
              act   <= 1'b0;
              state <= S_INIT_EN;
            end
          end
          S_INIT_EN: begin
            if (!act) begin
              ctr_o <= CTR_EN;
              go    <= 1'b1;
              act   <= 1'b1;
            end else if (done) begin
              act         <= 1'b0;
              req_ready_o <= 1'b1;
              state       <= S_IDLE;
            end
          end
          S_IDLE: begin
            if (req_valid_i && req_ready_o) begin
              rw          <= req_rw_i;
              sadr        <= req_sadr_i;
              madr        <= req_madr_i;
              wdata       <= req_wdata_i;
              step        <= '0;
              req_ready_o <= 1'b0;
              state       <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (!act) begin
              txr_o <= txr_n;
              cr_o  <= step_cr(rw, step);
              go    <= 1'b1;
              act   <= 1'b1;
            end else if (done) begin
              act   <= 1'b0;
              state <= S_POLL;
            end
          end
          S_POLL: begin
            if (!act) begin
              cr_o <= '0;
              go   <= 1'b1;
              act  <= 1'b1;
            end else if (done) begin
              act <= 1'b0;
              if (!sr_q[SR_TIP]) state <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (sr_q[SR_AL]) begin
              rsp_err_o   <= ERR_AL;
              rsp_valid_o <= 1'b1;
              state       <= S_RESP;
            end else if (sr_q[SR_RXACK] && wr_step) begin
              rsp_err_o <= ERR_NACK;
              state     <= S_STOP_ISSUE;
            end else if (step == last_step) begin
              if (rw) rsp_rdata_o <= rxr_i;
              rsp_err_o   <= ERR_OK;
              rsp_valid_o <= 1'b1;
              state       <= S_RESP;
            end else begin
              step  <= step + 2'd1;
              state <= S_ISSUE;
            end
          end
          S_STOP_ISSUE: begin
            if (!act) begin
              cr_o <= CR_STO;
              go   <= 1'b1;
              act  <= 1'b1;
            end else if (done) begin
              act   <= 1'b0;
              state <= S_STOP_POLL;
            end
          end
          S_STOP_POLL: begin
            if (!act) begin
              cr_o <= '0;
              go   <= 1'b1;
              act  <= 1'b1;
            end else if (done) begin
              act <= 1'b0;
              if (!sr_q[SR_TIP]) begin
                rsp_valid_o <= 1'b1;
                state       <= S_RESP;
              end
            end
          end
          S_RESP: begin
            req_ready_o <= 1'b1;
            state       <= S_IDLE;
          end
          default: state <= S_INIT_PRER;
        endcase
      end
    end
  end

endmodule
